// File: rtl/tcam_snoop_dispatch.sv
// Snoop dispatcher: drops the requester from the TCAM match set, queues survivors
// and emits one valid/ready snoop beat per remaining target node, lowest node first.
module tcam_snoop_dispatch #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int NODES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_tag,
  input  logic [6:0]       in_opcode,
  input  logic [6:0]       in_nid,
  input  logic [NODES-1:0] in_flag,
  output logic             snp_valid,
  input  logic             snp_ready,
  output logic [WIDTH-1:0] snp_tag,
  output logic [6:0]       snp_opcode,
  output logic [6:0]       snp_target,
  output logic             snp_last,
  output logic [15:0]      snp_count,
  output logic [15:0]      filt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 7 + NODES;
  localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
  localparam logic [NODES-1:0] NODE_ONE = NODES'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  function automatic logic [NODES-1:0] lowest_bit(input logic [NODES-1:0] m);
    return m & (~m + NODE_ONE);
  endfunction

  function automatic logic single_bit(input logic [NODES-1:0] m);
    return (m != '0) && ((m & (m - NODE_ONE)) == '0);
  endfunction

  function automatic logic [6:0] to_nid(input logic [NODES-1:0] m);
    logic [6:0] r;
    r = 7'd0;
    r[NODES-1:0] = m;
    return r;
  endfunction

  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r;
  logic             full_s, empty_s, accept_s, push_s, pop_s;
  logic [NODES-1:0] mask_s, rem_r, rem_next_s;
  logic [EW-1:0]    head_s;
  logic [WIDTH-1:0] head_tag_s;
  logic [6:0]       head_op_s;
  logic [NODES-1:0] head_mask_s;
  state_t           state_r;
  logic             snp_valid_r, snp_last_r;
  logic [WIDTH-1:0] snp_tag_r;
  logic [6:0]       snp_opcode_r, snp_target_r;
  logic [15:0]      snp_count_r, filt_count_r;
  logic             nid_unused_s;

  // Occupancy is judged from registered pointers only, so a same-cycle pop never frees a slot
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign in_ready = ~full_s;
  assign accept_s = in_valid & ~full_s;
  assign mask_s   = in_flag & ~in_nid[NODES-1:0];
  assign push_s   = accept_s & (mask_s != '0);
  assign nid_unused_s = ^in_nid;

  assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
  assign head_tag_s  = head_s[EW-1 -: WIDTH];
  assign head_op_s   = head_s[NODES +: 7];
  assign head_mask_s = head_s[NODES-1:0];
  assign rem_next_s  = rem_r & ~lowest_bit(rem_r);

  // Head is taken when idle, or back-to-back as the last beat of the active entry completes
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = ~empty_s;
      ISSUE:   pop_s = snp_ready & snp_last_r & ~empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= {in_tag, in_opcode, mask_s};
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Filtered-request counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) filt_count_r <= 16'd0;
    else if (accept_s && (mask_s == '0)) filt_count_r <= filt_count_r + 16'd1;
  end

  // Dispatcher FSM with registered snoop outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      rem_r        <= '0;
      snp_valid_r  <= 1'b0;
      snp_tag_r    <= '0;
      snp_opcode_r <= 7'd0;
      snp_target_r <= 7'd0;
      snp_last_r   <= 1'b0;
      snp_count_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r      <= ISSUE;
            rem_r        <= head_mask_s;
            snp_valid_r  <= 1'b1;
            snp_tag_r    <= head_tag_s;
            snp_opcode_r <= head_op_s;
            snp_target_r <= to_nid(lowest_bit(head_mask_s));
            snp_last_r   <= single_bit(head_mask_s);
          end
        end
        ISSUE: begin
          if (snp_ready) begin
            snp_count_r <= snp_count_r + 16'd1;
            if (pop_s) begin
              rem_r        <= head_mask_s;
              snp_tag_r    <= head_tag_s;
              snp_opcode_r <= head_op_s;
              snp_target_r <= to_nid(lowest_bit(head_mask_s));
              snp_last_r   <= single_bit(head_mask_s);
            end else if (snp_last_r) begin
              state_r      <= IDLE;
              rem_r        <= '0;
              snp_valid_r  <= 1'b0;
              snp_tag_r    <= '0;
              snp_opcode_r <= 7'd0;
              snp_target_r <= 7'd0;
              snp_last_r   <= 1'b0;
            end else begin
              rem_r        <= rem_next_s;
              snp_target_r <= to_nid(lowest_bit(rem_next_s));
              snp_last_r   <= single_bit(rem_next_s);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign snp_valid  = snp_valid_r;
  assign snp_tag    = snp_tag_r;
  assign snp_opcode = snp_opcode_r;
  assign snp_target = snp_target_r;
  assign snp_last   = snp_last_r;
  assign snp_count  = snp_count_r;
  assign filt_count = filt_count_r;

endmodule

// File: tb/tb_tcam_snoop_dispatch.sv
// Scoreboard bench for tcam_snoop_dispatch: stimulus pushes hand-computed beats,
// a negedge monitor pops and compares every snoop handshake.
module tb_tcam_snoop_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [32:0] in_tag;
  logic [6:0]  in_opcode, in_nid;
  logic [3:0]  in_flag;
  logic        snp_valid, snp_ready, snp_last;
  logic [32:0] snp_tag;
  logic [6:0]  snp_opcode, snp_target;
  logic [15:0] snp_count, filt_count;

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];

  tcam_snoop_dispatch #(.WIDTH(33), .DEPTH(4), .NODES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_opcode(in_opcode), .in_nid(in_nid), .in_flag(in_flag),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_tag(snp_tag),
    .snp_opcode(snp_opcode), .snp_target(snp_target), .snp_last(snp_last),
    .snp_count(snp_count), .filt_count(filt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [32:0] tag, input logic [6:0] op,
                             input logic [6:0] tgt, input logic last);
    exp_q.push_back({tag, op, tgt, last});
  endtask

  // Monitor: every completed handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && snp_valid && snp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {15'd0, snp_tag, snp_opcode, snp_target, snp_last}, 64'd0);
      end else begin
        chk("beat", {16'd0, snp_tag, snp_opcode, snp_target, snp_last}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [32:0] tag, input logic [6:0] op,
                      input logic [6:0] nid, input logic [3:0] flag);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_tag = tag; in_opcode = op; in_nid = nid; in_flag = flag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !snp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    reset = 1'b1; in_valid = 1'b0; snp_ready = 1'b0;
    in_tag = 33'd0; in_opcode = 7'd0; in_nid = 7'd0; in_flag = 4'd0;
    do_reset();

    // reset state
    chk("rst_valid", {63'd0, snp_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_snp_count", {48'd0, snp_count}, 64'd0);
    chk("rst_filt_count", {48'd0, filt_count}, 64'd0);
    chk("rst_target", {57'd0, snp_target}, 64'd0);

    // single request, two beats, first beat visible in cycle N+2
    snp_ready = 1'b1;
    expect_beat(33'h1_0000_00AB, 7'b0000111, 7'b0000010, 1'b0);
    expect_beat(33'h1_0000_00AB, 7'b0000111, 7'b0001000, 1'b1);
    send(33'h1_0000_00AB, 7'b0000111, 7'b0000001, 4'b1011);
    chk("lat_not_yet", {63'd0, snp_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_valid", {63'd0, snp_valid}, 64'd1);
    chk("lat_target", {57'd0, snp_target}, 64'h02);
    wait_idle(20);
    chk("single_snp_count", {48'd0, snp_count}, 64'd2);
    chk("single_filt_count", {48'd0, filt_count}, 64'd0);

    // filter drop
    send(33'h0_0000_0055, 7'd3, 7'b0000100, 4'b0100);
    chk("filt_count", {48'd0, filt_count}, 64'd1);
    repeat (4) @(posedge clk); #1;
    chk("filt_no_valid", {63'd0, snp_valid}, 64'd0);
    chk("filt_ready", {63'd0, in_ready}, 64'd1);
    chk("filt_snp_count", {48'd0, snp_count}, 64'd2);

    // back-pressure: 7 presented, 5 accepted
    snp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_tag = 33'h100 + 33'(i); in_opcode = 7'(i);
      in_nid = 7'b0000010; in_flag = 4'b0001;
      if (i < 5) expect_beat(33'h100 + 33'(i), 7'(i), 7'b0000001, 1'b1);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_not_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", {15'd0, snp_valid, snp_tag, snp_opcode, snp_target, snp_last},
          {15'd0, 1'b1, 33'h100, 7'd0, 7'b0000001, 1'b1});
    end
    @(posedge clk); #1;
    snp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
    wait_idle(40);
    chk("bp_snp_count", {48'd0, snp_count}, 64'd7);

    // back-to-back entries, no bubble
    snp_ready = 1'b0;
    expect_beat(33'h0_0000_0A01, 7'd9, 7'b0000010, 1'b1);
    expect_beat(33'h0_0000_0A02, 7'd10, 7'b0001000, 1'b1);
    send(33'h0_0000_0A01, 7'd9, 7'b0000001, 4'b0010);
    send(33'h0_0000_0A02, 7'd10, 7'b0000001, 4'b1000);
    snp_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_valid", {63'd0, snp_valid}, 64'd1);
    chk("b2b_target", {57'd0, snp_target}, 64'h08);
    chk("b2b_last", {63'd0, snp_last}, 64'd1);
    wait_idle(20);
    chk("b2b_snp_count", {48'd0, snp_count}, 64'd9);

    // reset after first handshake of a three-target entry
    expect_beat(33'h0_0000_0BEE, 7'd5, 7'b0000010, 1'b0);
    send(33'h0_0000_0BEE, 7'd5, 7'b0000001, 4'b1110);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, snp_valid}, 64'd0);
    chk("mid_rst_snp_count", {48'd0, snp_count}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_filt", {48'd0, filt_count}, 64'd0);
    chk("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("post_rst_idle", {63'd0, snp_valid}, 64'd0);
    chk("post_rst_count", {48'd0, snp_count}, 64'd0);

    // counter wrap after 65537 single-target beats
    do_reset();
    snp_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_tag = 33'(i); in_opcode = 7'(i);
      in_nid = 7'b0000010; in_flag = 4'b0001;
      expect_beat(33'(i), 7'(i), 7'b0000001, 1'b1);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("wrap_send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle(50);
    chk("wrap_snp_count", {48'd0, snp_count}, 64'd1);
    chk("wrap_filt_count", {48'd0, filt_count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
